// File: rtl/spine_link_buffer_pkg.sv
// Shared NoC definitions for the spine link buffer: flit geometry, ID encodings
// and the flit header field helper.
package spine_link_buffer_pkg;

  localparam int NOC_DWIDTH   = 16;
  localparam int NOC_AWIDTH   = 6;
  localparam int NOC_DEST_LSB = 10;
  localparam int NOC_DEPTH    = 8;
  localparam int NOC_CNT_W    = 16;

  typedef enum logic [1:0] {
    GROUP_ID_0 = 2'd0,
    GROUP_ID_1 = 2'd1,
    GROUP_ID_2 = 2'd2,
    GROUP_ID_3 = 2'd3
  } group_id_e;

  typedef enum logic [1:0] {
    ROUTER_ID_1 = 2'd0,
    ROUTER_ID_2 = 2'd1,
    ROUTER_ID_3 = 2'd2,
    ROUTER_ID_4 = 2'd3
  } router_id_e;

  function automatic logic [NOC_AWIDTH-1:0] get_dest(input logic [NOC_DWIDTH-1:0] flit);
    return flit[NOC_DEST_LSB +: NOC_AWIDTH];
  endfunction

endpackage

// File: rtl/spine_link_buffer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered occupancy count.
// Push and pop are pre-qualified by the parent; a push into a full FIFO is only
// issued together with a pop, which frees the very slot being written.
module spine_link_buffer_sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DWIDTH-1:0]        wdata,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [PW:0]       wr_ptr_r;
  logic [PW:0]       rd_ptr_r;
  logic [PW:0]       level_r;

  assign full  = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign rdata = mem_r[rd_ptr_r[PW-1:0]];
  assign level = level_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/spine_link_buffer.sv
// Egress buffer from a router spine output to a remote spine input: FIFO plus a
// registered output stage with ready handshake, overflow drop counting.
module spine_link_buffer
  import spine_link_buffer_pkg::*;
#(
  parameter int DWIDTH   = NOC_DWIDTH,
  parameter int DEPTH    = NOC_DEPTH,
  parameter int AWIDTH   = NOC_AWIDTH,
  parameter int DEST_LSB = NOC_DEST_LSB,
  parameter int CNT_W    = NOC_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  output logic [AWIDTH-1:0]        out_dest_addr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow_pulse
);

  logic [DWIDTH-1:0]      head_s;
  logic                   full_s;
  logic                   empty_s;
  logic [$clog2(DEPTH):0] level_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;

  logic [DWIDTH-1:0]      out_data_r;
  logic                   out_valid_r;
  logic [AWIDTH-1:0]      out_dest_r;
  logic [CNT_W-1:0]       drop_count_r;
  logic                   overflow_r;

  spine_link_buffer_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (in_data),
    .rdata  (head_s),
    .full   (full_s),
    .empty  (empty_s),
    .level  (level_s)
  );

  // Handshake: a pop in the same cycle makes room for a write into a full FIFO
  always_comb begin
    pop_s  = !empty_s && (!out_valid_r || out_ready);
    push_s = in_valid && (!full_s || pop_s);
    drop_s = in_valid && !push_s;
  end

  // Output stage: data and dest stay frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_dest_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (pop_s) begin
      out_data_r  <= head_s;
      out_dest_r  <= head_s[DEST_LSB +: AWIDTH];
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating drop counter and per-drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      overflow_r <= drop_s;
      if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
        drop_count_r <= drop_count_r + 1'b1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign out_data       = out_data_r;
  assign out_valid      = out_valid_r;
  assign out_dest_addr  = out_dest_r;
  assign fifo_level     = level_s;
  assign fifo_full      = full_s;
  assign fifo_empty     = empty_s;
  assign drop_count     = drop_count_r;
  assign overflow_pulse = overflow_r;

endmodule
